pool_unit: RTL and testbench
============================

Name: pool_unit

Overview:
- Subsampling (2x2, stride-2 max-pool) stage directly downstream of a convolution unit's ReLU output.
- Consumes the conv unit's output stream in raster order, one pixel per valid cycle.
- Emits pooled pixels together with a write address into the next-layer IFM memory, for use as the next convolution input.
- One instance per convolution unit.

Parameters:
- DATA_WIDTH, 32: pixel word width; IEEE-754 binary32 format.
- IFM_SIZE, 28: input feature-map side length (conv output side).
- OFM_SIZE, IFM_SIZE/2: output side length (floor).
- ADDRESS_SIZE_OFM, $clog2(OFM_SIZE*OFM_SIZE): output address width.
- COUNT_BITS, $clog2(IFM_SIZE): width of the row/col counters.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- pool_clear  input  1  synchronous frame abort; counters and state return to IDLE.
- data_in  input  DATA_WIDTH  conv/ReLU output pixel.
- data_in_valid  input  1  data_in is valid this cycle; there is no backpressure.
- data_out  output  DATA_WIDTH  pooled pixel.
- data_out_valid  output  1  data_out and ofm_address are valid.
- ofm_address  output  ADDRESS_SIZE_OFM  raster address of data_out in the next IFM memory.
- pool_busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse coincident with the last data_out_valid of a frame.

Behaviour:
- Reset values: all outputs 0; row = col = 0; state IDLE; hold register and line buffer contents don't-care, never read before being written within a frame.
- States:
  - IDLE -> RUN on the first data_in_valid.
  - RUN -> IDLE on the cycle that consumes pixel (IFM_SIZE-1, IFM_SIZE-1).
  - pool_clear forces IDLE from any state and wins over data_in_valid in the same cycle.
  - pool_busy = 1 in RUN. It also rises in the same cycle the first valid is accepted (combinational from state or valid).
- Counters:
  - Advance only on data_in_valid.
  - col wraps IFM_SIZE-1 -> 0 and then increments row.
  - row wraps to 0 after the last pixel, so a new frame can start on the very next cycle with no idle gap.
- Max compare:
  - Sign-magnitude ordering of binary32.
  - +0 and -0 compare equal.
  - On a tie the earlier operand is kept.
  - NaN inputs are not supported.
- Horizontal pairing:
  - On even col, data_in is latched into the hold register.
  - On odd col, pair = max(hold, data_in).
- Vertical pairing:
  - Even row, odd col: line_buf[col>>1] <= pair. Line buffer depth is OFM_SIZE.
  - Odd row, odd col: result = max(line_buf[col>>1], pair).
- Output register and latency:
  - result is registered. data_out_valid is high exactly one cycle after the input cycle that completes a 2x2 window.
  - Latency is 1 clock. Throughput is one output per 4 valid inputs.
  - ofm_address = (row>>1)*OFM_SIZE + (col>>1), registered together with data_out.
- data_out holds its last value while data_out_valid is 0.
- Odd IFM_SIZE: the last column and last row are consumed but never pooled (floor). They produce no output, and the frame still ends on pixel (IFM_SIZE-1, IFM_SIZE-1).
- frame_done:
  - Pulses with the output of window (OFM_SIZE-1, OFM_SIZE-1).
  - For odd IFM_SIZE it pulses one cycle after the final input pixel, with data_out_valid low.
- Gaps: valid may drop for any number of cycles mid-frame. State, hold register and line buffer are retained; no output is generated while valid is low.
- Asynchronous reset mid-frame: all state is abandoned immediately and the next valid is pixel (0,0).
- pool_clear in the same cycle as a window-completing pixel: that output is suppressed.

Optional Feature:
- Macro POOL_RELU_FUSE_EN.
- When defined: a sign-bit clamp is applied to the registered result. Any result with sign bit 1 is output as 0x00000000. This allows the conv unit's ReLU to be bypassed (relu_enable = 0) with identical network output.
- When undefined: the result passes unmodified and negative maxima propagate.
- Latency is unchanged in both cases.

Test Plan:
- IFM_SIZE=4; stream 1.0..16.0 raster, valid every cycle:
  - data_out = 6.0, 8.0, 14.0, 16.0 at addresses 0, 1, 2, 3.
  - Each output valid 1 cycle after pixel 5, 7, 13, 15 (0-based).
  - frame_done with the fourth output; pool_busy low afterwards.
- Same frame with a random 0–3 cycle valid gap between pixels: identical data and addresses; each output 1 cycle after its completing pixel.
- Negative and signed zero, window {-3.0, -1.0, -0.0, -2.0}:
  - Without the macro: output -0.0 (0x80000000), since -0.0 is the maximum and the tie with +0 does not arise.
  - With POOL_RELU_FUSE_EN: output 0x00000000.
  - Separately, window {+0.0, -0.0, -1.0, -1.0}: output 0x00000000 (tie keeps the earlier operand).
- Back-to-back frames (IFM_SIZE=4, 32 consecutive valid pixels): 8 outputs, addresses 0..3 twice, two frame_done pulses 16 cycles apart.
- Abort handling:
  - Assert reset asynchronously after pixel 9, then restart the frame: exactly 4 correct outputs, no stale window.
  - Repeat with pool_clear in place of reset: same result.
- IFM_SIZE=5; stream 25 pixels 1.0..25.0:
  - Outputs 7.0, 9.0, 17.0, 19.0.
  - frame_done 1 cycle after pixel 24, with data_out_valid low.

Source files
------------

// File: rtl/pool_unit.sv
`default_nettype none
// ============================================================================
// Module      : pool_unit
// Description : 2x2, stride-2 max-pool stage fed by a convolution unit's
//               ReLU output stream (raster order, one pixel per valid cycle).
//               Emits each pooled pixel with its raster write address into the
//               next-layer IFM memory. Pixels are IEEE-754 binary32, compared
//               in sign-magnitude order (+0 == -0, ties keep the earlier
//               operand, NaN unsupported).
// Revision    : 1.0 - initial release
//
// Compile-time option:
//   POOL_RELU_FUSE_EN - when defined, any pooled result with the sign bit set
//                       is output as 0x00000000 (ReLU fused into the pool).
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset, clears all state
//   pool_clear     in   synchronous frame abort (wins over data_in_valid)
//   data_in        in   conv/ReLU output pixel
//   data_in_valid  in   data_in valid this cycle (no backpressure)
//   data_out       out  pooled pixel, held while data_out_valid is low
//   data_out_valid out  data_out / ofm_address valid
//   ofm_address    out  raster address of data_out in the next IFM memory
//   pool_busy      out  frame in progress
//   frame_done     out  one-cycle pulse one cycle after the final frame pixel
// ============================================================================
module pool_unit #(
    parameter int DATA_WIDTH       = 32,
    parameter int IFM_SIZE         = 28,
    parameter int OFM_SIZE         = IFM_SIZE / 2,
    parameter int ADDRESS_SIZE_OFM = $clog2(OFM_SIZE * OFM_SIZE),
    parameter int COUNT_BITS       = $clog2(IFM_SIZE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pool_clear,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        data_in_valid,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        data_out_valid,
    output logic [ADDRESS_SIZE_OFM-1:0] ofm_address,
    output logic                        pool_busy,
    output logic                        frame_done
);

    localparam int LB_IDX_W = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
    localparam int MSB      = DATA_WIDTH - 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [COUNT_BITS-1:0]   r_row;
    logic [COUNT_BITS-1:0]   r_col;
    logic [DATA_WIDTH-1:0]   r_hold;
    logic [DATA_WIDTH-1:0]   r_line_buf [OFM_SIZE];
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic [ADDRESS_SIZE_OFM-1:0] r_addr;
    logic                    r_out_valid;
    logic                    r_frame_done;

    logic                    w_accept;
    logic                    w_col_last;
    logic                    w_row_last;
    logic                    w_frame_last;
    logic                    w_win_done;
    logic [LB_IDX_W-1:0]     w_lb_idx;
    logic [DATA_WIDTH-1:0]   w_lb_rd;
    logic [DATA_WIDTH-1:0]   w_pair;
    logic [DATA_WIDTH-1:0]   w_result;
    logic [DATA_WIDTH-1:0]   w_out;
    logic [ADDRESS_SIZE_OFM-1:0] w_addr;

    // True when the later operand is strictly greater than the earlier one,
    // so ties (including +0 vs -0) keep the earlier operand.
    function automatic logic later_wins(input logic [DATA_WIDTH-1:0] early,
                                        input logic [DATA_WIDTH-1:0] late);
        logic [DATA_WIDTH-2:0] m_e;
        logic [DATA_WIDTH-2:0] m_l;
        logic                  res;
        m_e = early[DATA_WIDTH-2:0];
        m_l = late[DATA_WIDTH-2:0];
        if ((m_e == '0) && (m_l == '0)) begin
            res = 1'b0;
        end else if (early[MSB] != late[MSB]) begin
            res = early[MSB];               // late is the positive one
        end else if (!early[MSB]) begin
            res = (m_l > m_e);
        end else begin
            res = (m_l < m_e);              // both negative: smaller magnitude wins
        end
        return res;
    endfunction

    assign w_accept     = data_in_valid & ~pool_clear;
    assign w_col_last   = (r_col == COUNT_BITS'(IFM_SIZE - 1));
    assign w_row_last   = (r_row == COUNT_BITS'(IFM_SIZE - 1));
    assign w_frame_last = w_col_last & w_row_last;
    // Odd row and odd column close a 2x2 window; for odd IFM_SIZE the last
    // row/column are even-indexed and therefore never complete a window.
    assign w_win_done   = w_accept & r_row[0] & r_col[0];
    assign w_lb_idx     = LB_IDX_W'(r_col >> 1);
    assign w_lb_rd      = r_line_buf[w_lb_idx];

    assign w_pair   = later_wins(r_hold, data_in) ? data_in : r_hold;
    assign w_result = later_wins(w_lb_rd, w_pair) ? w_pair : w_lb_rd;

`ifdef POOL_RELU_FUSE_EN
    assign w_out = w_result[MSB] ? '0 : w_result;
`else
    assign w_out = w_result;
`endif

    assign w_addr = ADDRESS_SIZE_OFM'(int'(r_row >> 1) * OFM_SIZE + int'(r_col >> 1));

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        pool_busy    = 1'b0;
        case (r_state)
            S_IDLE: begin
                pool_busy = w_accept;
                if (w_accept && !w_frame_last) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                pool_busy = 1'b1;
                if (pool_clear) begin
                    w_state_next = S_IDLE;
                end else if (data_in_valid && w_frame_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Raster counters; wrap at frame end so the next frame can follow
    // without an idle cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (pool_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (data_in_valid) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Hold register and line buffer are always written before being read
    // within a frame, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_accept && !r_col[0]) begin
            r_hold <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !r_row[0] && r_col[0]) begin
            r_line_buf[w_lb_idx] <= w_pair;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out   <= '0;
            r_addr       <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= w_win_done;
            r_frame_done <= w_accept & w_frame_last;
            if (w_win_done) begin
                r_data_out <= w_out;
                r_addr     <= w_addr;
            end
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_out_valid;
    assign ofm_address    = r_addr;
    assign frame_done     = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pool_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_unit
// Description : Self-checking bench for pool_unit. Two instances are built,
//               IFM_SIZE=4 (cfg 0) and IFM_SIZE=5 (cfg 1). Each has a
//               frame-buffer reference model that pools completed windows
//               with integer sign-magnitude keys, checked every cycle, plus
//               a vector table and directed corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  vin;
    logic [1:0]  clr;
    logic [31:0] din [2];

    int nvec;
    int nmis;
    int cyc;
    int out_cnt  [2];
    int done_cnt [2];
    int done_last[2];
    int done_prev[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Ordering key: binary32 sign-magnitude maps onto signed integers,
    // with both zeros mapping to 0.
    function automatic longint fkey(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] fbits(input int n);
        int e;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((n << (23 - e)) & 32'h7FFFFF)};
    endfunction

    function automatic logic [31:0] fneg(input int n);
        return fbits(n) | 32'h8000_0000;
    endfunction

    function automatic logic [31:0] rndf();
        logic [31:0] d;
        d = $urandom;
        if (d[30:23] == 8'hFF) d[30] = 1'b0;
        if ($urandom_range(0, 5) == 0) d = {d[31], 31'b0};
        return d;
    endfunction

    // ------------------------------------------------------------------
    // DUTs, reference models and per-cycle checkers
    // ------------------------------------------------------------------
    for (genvar U = 0; U < 2; U++) begin : g_cfg
        localparam int IFM = (U == 0) ? 4 : 5;
        localparam int OFM = IFM / 2;
        localparam int AW  = $clog2(OFM * OFM);

        logic [31:0]   dout;
        logic          dval;
        logic [AW-1:0] daddr;
        logic          dbusy;
        logic          ddone;

        pool_unit #(
            .DATA_WIDTH (32),
            .IFM_SIZE   (IFM)
        ) u_dut (
            .clk            (clk),
            .reset          (rst),
            .pool_clear     (clr[U]),
            .data_in        (din[U]),
            .data_in_valid  (vin[U]),
            .data_out       (dout),
            .data_out_valid (dval),
            .ofm_address    (daddr),
            .pool_busy      (dbusy),
            .frame_done     (ddone)
        );

        logic [31:0] fr [IFM*IFM];
        int          idx;
        int          r;
        int          c;
        logic [31:0] m;
        logic [31:0] w4 [4];
        logic        e_valid;
        logic        e_done;
        logic [31:0] e_data;
        int          e_addr;

        // Reference model: stores the frame, pools each completed window.
        initial begin
            idx = 0; e_valid = 1'b0; e_done = 1'b0; e_data = '0; e_addr = 0;
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    idx = 0; e_valid = 1'b0; e_done = 1'b0; e_data = '0; e_addr = 0;
                end else begin
                    e_valid = 1'b0;
                    e_done  = 1'b0;
                    if (clr[U]) begin
                        idx = 0;
                    end else if (vin[U]) begin
                        fr[idx] = din[U];
                        r = idx / IFM;
                        c = idx % IFM;
                        if ((r % 2 == 1) && (c % 2 == 1) && (r < 2*OFM) && (c < 2*OFM)) begin
                            w4[0] = fr[(r-1)*IFM + c-1];
                            w4[1] = fr[(r-1)*IFM + c];
                            w4[2] = fr[r*IFM + c-1];
                            w4[3] = fr[r*IFM + c];
                            m = w4[0];
                            for (int k = 1; k < 4; k++)
                                if (fkey(w4[k]) > fkey(m)) m = w4[k];
`ifdef POOL_RELU_FUSE_EN
                            if (m[31]) m = 32'h0;
`endif
                            e_valid = 1'b1;
                            e_data  = m;
                            e_addr  = (r / 2) * OFM + c / 2;
                        end
                        idx++;
                        if (idx == IFM*IFM) begin
                            idx    = 0;
                            e_done = 1'b1;
                        end
                    end
                end
            end
        end

        initial begin
            logic e_busy;
            logic bad;
            forever begin
                @(negedge clk);
                e_busy = (idx != 0) || (vin[U] && !clr[U]);
                bad = (dval !== e_valid) || (ddone !== e_done) || (dout !== e_data)
                      || (dbusy !== e_busy) || (e_valid && (int'(daddr) != e_addr));
                nvec++;
                if (bad) begin
                    nmis++;
                    $display("FAIL model cfg%0d cyc%0d: valid %b exp %b, data %h exp %h, addr %0d exp %0d, done %b exp %b, busy %b exp %b",
                             U, cyc, dval, e_valid, dout, e_data, daddr, e_addr, ddone, e_done, dbusy, e_busy);
                end
                if (dval === 1'b1) out_cnt[U]++;
                if (ddone === 1'b1) begin
                    done_cnt[U]++;
                    done_prev[U] = done_last[U];
                    done_last[U] = cyc;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic px(input int u, input logic [31:0] d);
        vin[u] = 1'b1;
        din[u] = d;
        @(posedge clk); #1;
        vin[u] = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic ramp_frame(input int u, input int n);
        for (int k = 0; k < n; k++) px(u, fbits(k + 1));
    endtask

    typedef struct {
        int          pix;
        bit          ev;
        logic [31:0] ed;
        int          ea;
        bit          edone;
    } vec_t;

    vec_t        tbl [16];
    logic [31:0] frm [16];
    logic [31:0] exp_neg;
    int          o0;
    int          d0;

    initial begin
        // Vector table: 4x4 ramp, window outputs after pixels 5, 7, 13, 15.
        for (int k = 0; k < 16; k++) begin
            tbl[k].pix = k + 1; tbl[k].ev = 1'b0; tbl[k].ed = '0;
            tbl[k].ea = 0; tbl[k].edone = 1'b0;
        end
        tbl[5].ev  = 1'b1; tbl[5].ed  = fbits(6);  tbl[5].ea  = 0;
        tbl[7].ev  = 1'b1; tbl[7].ed  = fbits(8);  tbl[7].ea  = 1;
        tbl[13].ev = 1'b1; tbl[13].ed = fbits(14); tbl[13].ea = 2;
        tbl[15].ev = 1'b1; tbl[15].ed = fbits(16); tbl[15].ea = 3; tbl[15].edone = 1'b1;

        nvec = 0; nmis = 0; cyc = 0;
        for (int u = 0; u < 2; u++) begin
            out_cnt[u] = 0; done_cnt[u] = 0; done_last[u] = 0; done_prev[u] = 0;
            din[u] = '0;
        end
        vin = '0; clr = '0;
        rst = 1'b1;
        idle(3);
        chk("reset data_out", g_cfg[0].dout, 32'h0);
        chk("reset valid", 32'(g_cfg[0].dval), 32'h0);
        chk("reset busy", 32'(g_cfg[0].dbusy), 32'h0);
        chk("reset done", 32'(g_cfg[0].ddone), 32'h0);
        chk("reset addr", 32'(g_cfg[0].daddr), 32'h0);
        rst = 1'b0;
        idle(2);

        // Table-driven 4x4 ramp, valid every cycle.
        for (int i = 0; i < 16; i++) begin
            vin[0] = 1'b1;
            din[0] = fbits(tbl[i].pix);
            @(posedge clk); #2;
            chk($sformatf("tbl%0d valid", i), 32'(g_cfg[0].dval), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d done", i), 32'(g_cfg[0].ddone), 32'(tbl[i].edone));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d data", i), g_cfg[0].dout, tbl[i].ed);
                chk($sformatf("tbl%0d addr", i), 32'(g_cfg[0].daddr), 32'(tbl[i].ea));
            end
        end
        vin[0] = 1'b0;
        #1;
        chk("busy after frame", 32'(g_cfg[0].dbusy), 32'h0);
        idle(2);

        // Same frame with random 0..3 cycle gaps.
        for (int k = 0; k < 16; k++) begin
            idle($urandom_range(0, 3));
            px(0, fbits(k + 1));
            if (tbl[k].ev) begin
                chk($sformatf("gap%0d valid", k), 32'(g_cfg[0].dval), 32'h1);
                chk($sformatf("gap%0d data", k), g_cfg[0].dout, tbl[k].ed);
                chk($sformatf("gap%0d addr", k), 32'(g_cfg[0].daddr), 32'(tbl[k].ea));
            end
        end
        idle(2);

        // Negative values and signed zeros.
`ifdef POOL_RELU_FUSE_EN
        exp_neg = 32'h0000_0000;
`else
        exp_neg = 32'h8000_0000;
`endif
        for (int k = 0; k < 16; k++) frm[k] = fbits(k + 1);
        frm[0] = fneg(3); frm[1] = fneg(1); frm[4] = 32'h8000_0000; frm[5] = fneg(2);
        frm[2] = 32'h0;   frm[3] = 32'h8000_0000; frm[6] = fneg(1); frm[7] = fneg(1);
        for (int k = 0; k < 16; k++) begin
            px(0, frm[k]);
            if (k == 5) chk("neg window", g_cfg[0].dout, exp_neg);
            if (k == 7) chk("zero tie window", g_cfg[0].dout, 32'h0);
        end
        idle(2);

        // Back-to-back frames: 32 consecutive valid pixels.
        o0 = out_cnt[0];
        d0 = done_cnt[0];
        ramp_frame(0, 16);
        ramp_frame(0, 16);
        idle(2);
        chk("b2b outputs", 32'(out_cnt[0] - o0), 32'd8);
        chk("b2b done pulses", 32'(done_cnt[0] - d0), 32'd2);
        chk("b2b done spacing", 32'(done_last[0] - done_prev[0]), 32'd16);

        // Asynchronous reset mid-frame after pixel 9, then restart.
        ramp_frame(0, 10);
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        idle(1);
        o0 = out_cnt[0];
        ramp_frame(0, 16);
        idle(2);
        chk("reset abort outputs", 32'(out_cnt[0] - o0), 32'd4);

        // Same abort with pool_clear.
        ramp_frame(0, 10);
        clr[0] = 1'b1;
        idle(1);
        clr[0] = 1'b0;
        o0 = out_cnt[0];
        ramp_frame(0, 16);
        idle(2);
        chk("clear abort outputs", 32'(out_cnt[0] - o0), 32'd4);

        // pool_clear coincident with a window-completing pixel.
        ramp_frame(0, 5);
        vin[0] = 1'b1; clr[0] = 1'b1; din[0] = fbits(6);
        @(posedge clk); #1;
        vin[0] = 1'b0; clr[0] = 1'b0;
        chk("clear suppresses output", 32'(g_cfg[0].dval), 32'h0);
        ramp_frame(0, 16);
        idle(2);

        // Random frames with random gaps on both configurations.
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 16; k++) begin
                idle($urandom_range(0, 2));
                px(0, rndf());
            end
            for (int k = 0; k < 25; k++) begin
                idle($urandom_range(0, 2));
                px(1, rndf());
            end
        end
        idle(2);

        // Odd IFM_SIZE=5 ramp.
        for (int k = 0; k < 25; k++) begin
            px(1, fbits(k + 1));
            if (k == 6)  chk("ifm5 out0", g_cfg[1].dout, fbits(7));
            if (k == 8)  chk("ifm5 out1", g_cfg[1].dout, fbits(9));
            if (k == 16) chk("ifm5 out2", g_cfg[1].dout, fbits(17));
            if (k == 18) chk("ifm5 out3", g_cfg[1].dout, fbits(19));
            if (k == 24) begin
                chk("ifm5 done", 32'(g_cfg[1].ddone), 32'h1);
                chk("ifm5 valid at done", 32'(g_cfg[1].dval), 32'h0);
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
